// File: rtl/net_tx_pkg.sv
// net_tx_pkg: shared types and constants for the UDP transmit scheduler.
//   frame_type_t  - header type nibble (BTN/TEST/KA)
//   sched_state_t - scheduler FSM states
//   TEST_PATTERN  - payload words cycled by test frames
package net_tx_pkg;
    localparam int TYPE_W = 4;
    localparam int SEQ_W  = 12;
    typedef enum logic [TYPE_W-1:0] {
        FT_BTN  = 4'd1,
        FT_TEST = 4'd2,
        FT_KA   = 4'd3
    } frame_type_t;
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} sched_state_t;
    localparam logic [15:0] TEST_PATTERN [4] = '{16'hABCD, 16'h6969, 16'hFFFF, 16'h0420};
endpackage

// File: rtl/keepalive_timer.sv
// keepalive_timer: idle-cycle counter that pulses expire every CYCLES running cycles.
//   Built only when TX_KEEPALIVE_EN is defined.
//   clk, rst (async, active-high), run (count enable), clear (restart count),
//   expire (combinational pulse in the cycle the count reaches CYCLES-1).
`ifdef TX_KEEPALIVE_EN
module keepalive_timer #(
    parameter int CYCLES = 2_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expire
);
    localparam int W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    logic [W-1:0] cnt;
    assign expire = run && !clear && (cnt == W'(CYCLES - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear || expire)
            cnt <= '0;
        else if (run)
            cnt <= cnt + 1'b1;
    end
endmodule
`endif

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: arbitrates button, test and keepalive sources onto the UDP tx AXI stream.
//   clk (eth_refclk), rst (async, active-high)
//   btn_valid/btn_data - controller samples; test_req - debounced test button level
//   axiov/axiod        - fixed-length 16-bit word burst to network_stack_tx
//   busy               - high during SEND and GAP
//   frame_count        - frames fully sent (wraps); coalesce_count - overwritten button changes (saturates)
//   Optional keepalive source enabled by defining TX_KEEPALIVE_EN.
module tx_frame_scheduler
    import net_tx_pkg::*;
#(
    parameter int PAYLOAD_WORDS    = 16,
    parameter int GAP_CYCLES       = 64,
    parameter int KEEPALIVE_CYCLES = 2_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_valid,
    input  logic [7:0]  btn_data,
    input  logic        test_req,
    output logic        axiov,
    output logic [15:0] axiod,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [7:0]  coalesce_count
);
    localparam int WW = $clog2(PAYLOAD_WORDS);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    if (PAYLOAD_WORDS < 2 || GAP_CYCLES < 1 || KEEPALIVE_CYCLES < 2) begin : g_bad_params
        $error("tx_frame_scheduler: illegal parameter value");
    end

    sched_state_t     state;
    frame_type_t      f_type, g_type;
    logic [7:0]       f_snap, g_snap, btn_last, btn_snap, ka_snap;
    logic [SEQ_W-1:0] seq;
    logic [WW-1:0]    widx;
    logic [GW-1:0]    gcnt;
    logic [1:0]       pidx;
    logic             btn_pending, test_pending, ka_pending, test_prev;
    logic             btn_event, test_edge, test_block, grant, grant_btn, grant_test;
    logic [15:0]      nxt_word;

    assign btn_event  = btn_valid && (btn_data != btn_last);
    assign test_edge  = test_req && !test_prev;
    // A test edge is dropped while one is queued or a test frame is still on the wire.
    assign test_block = test_pending || (state != ST_IDLE && f_type == FT_TEST);
    assign grant      = (state == ST_IDLE) && (btn_pending || test_pending || ka_pending);
    assign g_type     = btn_pending ? FT_BTN : test_pending ? FT_TEST : FT_KA;
    assign g_snap     = btn_pending ? btn_snap : ka_snap;
    assign grant_btn  = grant && btn_pending;
    assign grant_test = grant && !btn_pending && test_pending;
    assign nxt_word   = (f_type == FT_TEST) ? TEST_PATTERN[pidx] : {f_snap, f_snap};

`ifdef TX_KEEPALIVE_EN
    logic ka_expire;
    keepalive_timer #(.CYCLES(KEEPALIVE_CYCLES)) u_ka_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (state == ST_IDLE),
        .clear  (grant),
        .expire (ka_expire)
    );
    // Any grant retires the keepalive: a button or test frame already proves the link is alive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ka_pending <= 1'b0;
            ka_snap    <= 8'h00;
        end else if (grant) begin
            ka_pending <= 1'b0;
        end else if (ka_expire) begin
            ka_pending <= 1'b1;
            ka_snap    <= btn_last;
        end
    end
`else
    assign ka_pending = 1'b0;
    assign ka_snap    = 8'h00;
`endif

    // Source capture; a new button change in the grant cycle re-arms btn_pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_last       <= 8'h00;
            btn_snap       <= 8'h00;
            btn_pending    <= 1'b0;
            coalesce_count <= 8'h00;
            test_prev      <= 1'b0;
            test_pending   <= 1'b0;
        end else begin
            test_prev <= test_req;
            if (btn_event) begin
                btn_last    <= btn_data;
                btn_snap    <= btn_data;
                btn_pending <= 1'b1;
                if (btn_pending && !grant_btn && coalesce_count != 8'hFF)
                    coalesce_count <= coalesce_count + 8'd1;
            end else if (grant_btn) begin
                btn_pending <= 1'b0;
            end
            if (grant_test)
                test_pending <= 1'b0;
            else if (test_edge && !test_block)
                test_pending <= 1'b1;
        end
    end

    // Frame FSM with registered stream outputs; axiod always carries the word for the current cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            axiov       <= 1'b0;
            axiod       <= 16'h0000;
            busy        <= 1'b0;
            frame_count <= 16'h0000;
            seq         <= '0;
            widx        <= '0;
            gcnt        <= '0;
            pidx        <= 2'd0;
            f_type      <= FT_BTN;
            f_snap      <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: if (grant) begin
                    state  <= ST_SEND;
                    axiov  <= 1'b1;
                    busy   <= 1'b1;
                    axiod  <= {g_type, seq};
                    f_type <= g_type;
                    f_snap <= g_snap;
                    widx   <= '0;
                    pidx   <= 2'd0;
                end
                ST_SEND: if (widx == WW'(PAYLOAD_WORDS - 1)) begin
                    state       <= ST_GAP;
                    axiov       <= 1'b0;
                    axiod       <= 16'h0000;
                    seq         <= seq + 1'b1;
                    frame_count <= frame_count + 16'd1;
                    gcnt        <= '0;
                end else begin
                    axiod <= nxt_word;
                    widx  <= widx + 1'b1;
                    pidx  <= pidx + 2'd1;
                end
                ST_GAP: if (gcnt == GW'(GAP_CYCLES - 1)) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end else begin
                    gcnt <= gcnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb_tx_frame_scheduler: directed scoreboard bench for tx_frame_scheduler.
module tb_tx_frame_scheduler;
    localparam int PW  = 8;
    localparam int GAP = 4;
    localparam int KAC = 100;

    logic        clk = 1'b0, rst = 1'b1, btn_valid = 1'b0, test_req = 1'b0;
    logic [7:0]  btn_data = 8'h00;
    logic        axiov, busy;
    logic [15:0] axiod, frame_count;
    logic [7:0]  coalesce_count;

    tx_frame_scheduler #(.PAYLOAD_WORDS(PW), .GAP_CYCLES(GAP), .KEEPALIVE_CYCLES(KAC)) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_valid      (btn_valid),
        .btn_data       (btn_data),
        .test_req       (test_req),
        .axiov          (axiov),
        .axiod          (axiod),
        .busy           (busy),
        .frame_count    (frame_count),
        .coalesce_count (coalesce_count)
    );

    always #10 clk = ~clk;

    int          checks = 0, errors = 0;
    logic [15:0] exp_q[$];
    int          exp_seq = 0;
    int          low_run = 0, last_gap = -1;
    logic        seen_high = 1'b0, prev_v = 1'b0;
    logic [15:0] mon_w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [3:0] t, input logic [7:0] s);
        logic [15:0] pat [4];
        pat = '{16'hABCD, 16'h6969, 16'hFFFF, 16'h0420};
        exp_q.push_back({t, exp_seq[11:0]});
        for (int i = 1; i < PW; i++)
            exp_q.push_back((t == 4'd2) ? pat[(i - 1) % 4] : {s, s});
        exp_seq = (exp_seq + 1) % 4096;
    endtask

    task automatic btn(input logic [7:0] v);
        @(negedge clk);
        btn_valid = 1'b1;
        btn_data  = v;
        @(negedge clk);
        btn_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input string tag);
        int k = 0;
        while (frame_count !== 16'(n) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {16'h0, frame_count}, 32'(16'(n)));
    endtask

    task automatic wait_axiov();
        int k = 0;
        while (axiov !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("axiov_rise", {31'h0, axiov}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        btn_valid = 1'b0;
        test_req  = 1'b0;
        exp_q.delete();
        exp_seq   = 0;
        seen_high = 1'b0;
        low_run   = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard consumer: every valid word must match the next expected word.
    always @(negedge clk) begin
        if (axiov) begin
            if (!prev_v && seen_high) last_gap = low_run;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_word observed=%h expected=none", axiod);
            end
            if (exp_q.size() != 0) begin
                mon_w = exp_q.pop_front();
                checks++;
                assert (axiod === mon_w) else begin
                    errors++;
                    $error("FAIL stream_word observed=%h expected=%h", axiod, mon_w);
                end
            end
            low_run   = 0;
            seen_high = 1'b1;
        end else begin
            low_run++;
        end
        prev_v = axiov;
    end

    initial begin
        logic [7:0] v;
        repeat (3) @(negedge clk);
        chk("rst_axiov", {31'h0, axiov}, 32'd0);
        chk("rst_axiod", {16'h0, axiod}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_frame_count", {16'h0, frame_count}, 32'd0);
        chk("rst_coalesce", {24'h0, coalesce_count}, 32'd0);

        // single change, with 2-cycle latency
        push_frame(4'd1, 8'h05);
        @(negedge clk);
        btn_valid = 1'b1;
        btn_data  = 8'h05;
        @(negedge clk);
        btn_valid = 1'b0;
        chk("latency_low", {31'h0, axiov}, 32'd0);
        @(negedge clk);
        chk("latency_high", {31'h0, axiov}, 32'd1);
        chk("busy_send", {31'h0, busy}, 32'd1);
        wait_frames(1, "single_frames");

        // test burst; second edge during SEND is dropped
        push_frame(4'd2, 8'h00);
        @(negedge clk);
        test_req = 1'b1;
        @(negedge clk);
        test_req = 1'b0;
        wait_axiov();
        repeat (2) @(negedge clk);
        test_req = 1'b1;
        @(negedge clk);
        test_req = 1'b0;
        wait_frames(2, "test_frames");
        repeat (PW + GAP + 10) @(negedge clk);
        chk("test_no_extra", {16'h0, frame_count}, 32'd2);

        // coalescing during SEND
        push_frame(4'd1, 8'h10);
        btn(8'h10);
        wait_axiov();
        btn(8'h01);
        btn(8'h02);
        push_frame(4'd1, 8'h02);
        wait_frames(4, "coalesce_frames");
        chk("coalesce_count", {24'h0, coalesce_count}, 32'd1);
        chk("gap_len", 32'(last_gap), 32'(GAP + 1));

        // priority: button and test edge together
        do_reset();
        chk("reset_coalesce", {24'h0, coalesce_count}, 32'd0);
        push_frame(4'd1, 8'h33);
        push_frame(4'd2, 8'h00);
        @(negedge clk);
        btn_valid = 1'b1;
        btn_data  = 8'h33;
        test_req  = 1'b1;
        @(negedge clk);
        btn_valid = 1'b0;
        test_req  = 1'b0;
        wait_frames(1, "prio_first");
        wait_frames(2, "prio_second");

        // sequence wrap: frame 4097 after reset carries seq 0
        for (int i = 0; i < 4095; i++) begin
            v = i[0] ? 8'hAA : 8'h55;
            push_frame(4'd1, v);
            btn(v);
            wait_frames(3 + i, "wrap_frames");
        end
        chk("wrap_model_seq", 32'(exp_seq), 32'd1);

        // asynchronous reset at word 7
        push_frame(4'd1, 8'h77);
        btn(8'h77);
        wait_axiov();
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_axiov", {31'h0, axiov}, 32'd0);
        chk("midrst_busy", {31'h0, busy}, 32'd0);
        chk("midrst_frames", {16'h0, frame_count}, 32'd0);
        chk("midrst_coalesce", {24'h0, coalesce_count}, 32'd0);
        exp_seq   = 0;
        seen_high = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // keepalive after a long idle period
`ifdef TX_KEEPALIVE_EN
        push_frame(4'd3, 8'h00);
        repeat (KAC + PW + GAP + 20) @(negedge clk);
        chk("keepalive_frames", {16'h0, frame_count}, 32'd1);
`else
        repeat (KAC + PW + GAP + 20) @(negedge clk);
        chk("keepalive_frames", {16'h0, frame_count}, 32'd0);
`endif
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
